// File: rtl/blink_timer_sequencer.sv
// Run-control sequencer for the countdown/LED-blink datapath: idle, slow blink, fast blink,
// paused and done. Define BLINK_SEQ_AUTO_RELOAD_EN to reload the countdown instead of stopping.
module blink_timer_sequencer #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned TIMER_INIT  = 100,
  parameter int unsigned FAST_THRESH = 50,
  parameter int unsigned PERIOD      = 10,
  parameter int unsigned ON_TICKS    = 5
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [6:0] load_val,
  output logic       LED,
  output logic [6:0] timer,
  output logic [2:0] state,
  output logic       tick,
  output logic       done
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PhW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TICK_DIV - 1);
  localparam logic [PhW-1:0]  PhMax   = PhW'(PERIOD - 1);
  localparam logic [PhW-1:0]  OnTicks = PhW'(ON_TICKS);
  localparam logic [6:0]      InitV   = 7'(TIMER_INIT);
  localparam logic [6:0]      Thresh  = 7'(FAST_THRESH);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSlow  = 3'd1,
    StFast  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e          r_state, w_state_nxt;
  logic            r_ret_fast, w_ret_fast_nxt;
  logic [6:0]      r_timer, w_timer_nxt;
  logic [PhW-1:0]  r_phase, w_phase_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_led, w_led_nxt;
  logic            r_done, w_done_nxt;
  logic            r_tick, w_tick_nxt;
`ifdef BLINK_SEQ_AUTO_RELOAD_EN
  logic [6:0]      r_last_v, w_last_v_nxt;
`endif

  logic [6:0]     w_v;
  logic [6:0]     w_dec;
  logic [PhW-1:0] w_ph_inc;

  assign w_v      = (load_val == 7'd0) ? InitV : load_val;
  assign w_dec    = (r_timer == 7'd0) ? 7'd0 : r_timer - 7'd1;
  assign w_ph_inc = (r_phase == PhMax) ? '0 : r_phase + 1'b1;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= StIdle;
      r_ret_fast <= 1'b0;
      r_timer    <= 7'd0;
      r_phase    <= '0;
      r_cnt      <= CntMax;
      r_led      <= 1'b0;
      r_done     <= 1'b0;
      r_tick     <= 1'b0;
`ifdef BLINK_SEQ_AUTO_RELOAD_EN
      r_last_v   <= 7'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ret_fast <= w_ret_fast_nxt;
      r_timer    <= w_timer_nxt;
      r_phase    <= w_phase_nxt;
      r_cnt      <= w_cnt_nxt;
      r_led      <= w_led_nxt;
      r_done     <= w_done_nxt;
      r_tick     <= w_tick_nxt;
`ifdef BLINK_SEQ_AUTO_RELOAD_EN
      r_last_v   <= w_last_v_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ret_fast_nxt = r_ret_fast;
    w_timer_nxt    = r_timer;
    w_phase_nxt    = r_phase;
    w_cnt_nxt      = r_cnt;
    w_led_nxt      = r_led;
    w_done_nxt     = r_done;
    w_tick_nxt     = 1'b0;
`ifdef BLINK_SEQ_AUTO_RELOAD_EN
    w_last_v_nxt   = r_last_v;
    w_done_nxt     = 1'b0;
`endif

    if (clear) begin
      w_state_nxt = StIdle;
      w_timer_nxt = 7'd0;
      w_led_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_phase_nxt = '0;
      w_cnt_nxt   = CntMax;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            w_timer_nxt = w_v;
            w_phase_nxt = '0;
            w_done_nxt  = 1'b0;
            w_led_nxt   = 1'b1;
            w_cnt_nxt   = CntMax;
            w_state_nxt = (w_v > Thresh) ? StSlow : StFast;
`ifdef BLINK_SEQ_AUTO_RELOAD_EN
            w_last_v_nxt = w_v;
`endif
          end
        end
        StSlow, StFast: begin
          if (r_cnt == '0) begin
            w_cnt_nxt   = CntMax;
            w_tick_nxt  = 1'b1;
            w_timer_nxt = w_dec;
            if (r_state == StSlow) begin
              w_phase_nxt = w_ph_inc;
              w_led_nxt   = (w_ph_inc < OnTicks);
              if (w_dec <= Thresh) begin
                w_state_nxt = StFast;
                w_led_nxt   = ~r_led;
              end
            end else begin
              w_led_nxt = ~r_led;
            end
            // Reaching zero overrides the slow-to-fast switch.
            if (w_dec == 7'd0) begin
`ifdef BLINK_SEQ_AUTO_RELOAD_EN
              w_timer_nxt = r_last_v;
              w_phase_nxt = '0;
              w_led_nxt   = 1'b1;
              w_done_nxt  = 1'b1;
              w_state_nxt = (r_last_v > Thresh) ? StSlow : StFast;
`else
              w_state_nxt = StDone;
              w_led_nxt   = 1'b0;
              w_done_nxt  = 1'b1;
`endif
            end
          end else if (!pause) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
          // A coinciding tick is applied first; a finished count is not paused.
          if (pause && (w_state_nxt != StDone)) begin
            w_ret_fast_nxt = (w_state_nxt == StFast);
            w_state_nxt    = StPause;
          end
        end
        StPause: begin
          if (start) w_state_nxt = r_ret_fast ? StFast : StSlow;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  assign LED   = r_led;
  assign timer = r_timer;
  assign state = r_state;
  assign tick  = r_tick;
  assign done  = r_done;

endmodule

// File: tb/tb_blink_timer_sequencer.sv
// Directed bench for blink_timer_sequencer with TICK_DIV=4; covers BLINK_SEQ_AUTO_RELOAD_EN too.
module tb_blink_timer_sequencer;

  logic       Clock_50;
  logic       Resetn;
  logic       start;
  logic       pause;
  logic       clear;
  logic [6:0] load_val;
  logic       LED;
  logic [6:0] timer;
  logic [2:0] state;
  logic       tick;
  logic       done;

  int errors = 0;
  int checks = 0;

  blink_timer_sequencer #(
    .TICK_DIV   (4),
    .TIMER_INIT (100),
    .FAST_THRESH(50),
    .PERIOD     (10),
    .ON_TICKS   (5)
  ) u_dut (
    .Clock_50(Clock_50),
    .Resetn  (Resetn),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .load_val(load_val),
    .LED     (LED),
    .timer   (timer),
    .state   (state),
    .tick    (tick),
    .done    (done)
  );

  initial begin
    Clock_50 = 1'b0;
    forever #5 Clock_50 = ~Clock_50;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock_50);
      @(negedge Clock_50);
    end
  endtask

  task automatic do_start(input logic [6:0] lv);
    load_val = lv;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  // Counts clock edges until tick is seen, giving up after 20.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (tick !== 1'b1 && n < 20);
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    #12;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (timer !== 7'd0) begin errors++; $display("FAIL reset_timer got=%0d exp=0", timer); end
    checks++; if (LED !== 1'b0) begin errors++; $display("FAIL reset_led got=%b exp=0", LED); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    @(negedge Clock_50);
    Resetn = 1'b1;
    cyc(1);
  endtask

  task automatic test_slow_pattern();
    logic [9:0] pat;
    int n;
    pat = 10'b1000001111;
    do_start(7'd0);
    checks++; if (timer !== 7'd100) begin errors++; $display("FAIL slow_load_timer got=%0d exp=100", timer); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL slow_load_state got=%0d exp=1", state); end
    checks++; if (LED !== 1'b1) begin errors++; $display("FAIL slow_load_led got=%b exp=1", LED); end
    for (int k = 0; k < 10; k++) begin
      wait_tick(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL slow_tick_period k=%0d got=%0d exp=4", k, n); end
      checks++; if (LED !== pat[k]) begin errors++; $display("FAIL slow_led k=%0d got=%b exp=%b", k, LED, pat[k]); end
      checks++; if (timer !== 7'(99 - k)) begin errors++; $display("FAIL slow_timer k=%0d got=%0d exp=%0d", k, timer, 99 - k); end
    end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL slow_state_end got=%0d exp=1", state); end
  endtask

  task automatic test_fast_threshold();
    logic [6:0] exp_t [5];
    logic       exp_l [5];
    logic [2:0] exp_s [5];
    int n;
    exp_t = '{7'd52, 7'd51, 7'd50, 7'd49, 7'd48};
    exp_l = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_s = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
    do_clear();
    do_start(7'd53);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL thr_load_state got=%0d exp=1", state); end
    for (int k = 0; k < 5; k++) begin
      wait_tick(n);
      checks++; if (timer !== exp_t[k]) begin errors++; $display("FAIL thr_timer k=%0d got=%0d exp=%0d", k, timer, exp_t[k]); end
      checks++; if (LED !== exp_l[k]) begin errors++; $display("FAIL thr_led k=%0d got=%b exp=%b", k, LED, exp_l[k]); end
      checks++; if (state !== exp_s[k]) begin errors++; $display("FAIL thr_state k=%0d got=%0d exp=%0d", k, state, exp_s[k]); end
    end
  endtask

  task automatic test_done();
    int n;
    logic held;
    do_clear();
    do_start(7'd3);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL done_load_state got=%0d exp=2", state); end
    checks++; if (LED !== 1'b1) begin errors++; $display("FAIL done_load_led got=%b exp=1", LED); end
    wait_tick(n);
    checks++; if (timer !== 7'd2 || LED !== 1'b0) begin errors++; $display("FAIL done_t1 got=%0d/%b exp=2/0", timer, LED); end
    wait_tick(n);
    checks++; if (timer !== 7'd1 || LED !== 1'b1) begin errors++; $display("FAIL done_t2 got=%0d/%b exp=1/1", timer, LED); end
    wait_tick(n);
    checks++; if (timer !== 7'd0) begin errors++; $display("FAIL done_timer got=%0d exp=0", timer); end
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL done_state got=%0d exp=4", state); end
    checks++; if (LED !== 1'b0) begin errors++; $display("FAIL done_led got=%b exp=0", LED); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_flag got=%b exp=1", done); end
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (done !== 1'b1 || state !== 3'd4 || tick !== 1'b0 || timer !== 7'd0) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL done_held got=%b exp=1", held); end
    do_start(7'd2);
    checks++; if (state !== 3'd2 || timer !== 7'd2) begin errors++; $display("FAIL done_restart got=%0d/%0d exp=2/2", state, timer); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_restart_flag got=%b exp=0", done); end
  endtask

  task automatic test_auto_reload();
    int n;
    do_clear();
    do_start(7'd2);
    checks++; if (state !== 3'd2 || timer !== 7'd2) begin errors++; $display("FAIL auto_load got=%0d/%0d exp=2/2", state, timer); end
    wait_tick(n);
    checks++; if (timer !== 7'd1 || done !== 1'b0) begin errors++; $display("FAIL auto_t1 got=%0d/%b exp=1/0", timer, done); end
    wait_tick(n);
    checks++; if (timer !== 7'd2) begin errors++; $display("FAIL auto_timer got=%0d exp=2", timer); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL auto_done_pulse got=%b exp=1", done); end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL auto_state got=%0d exp=2", state); end
    checks++; if (LED !== 1'b1) begin errors++; $display("FAIL auto_led got=%b exp=1", LED); end
    cyc(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL auto_done_len got=%b exp=0", done); end
  endtask

  task automatic test_pause();
    int n;
    logic held;
    do_clear();
    do_start(7'd0);
    wait_tick(n);
    checks++; if (timer !== 7'd99 || LED !== 1'b1) begin errors++; $display("FAIL pause_pre got=%0d/%b exp=99/1", timer, LED); end
    cyc(2);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pause_state got=%0d exp=3", state); end
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) pause = 1'b1;
      cyc(1);
      pause = 1'b0;
      if (state !== 3'd3 || timer !== 7'd99 || LED !== 1'b1 || tick !== 1'b0) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL pause_hold got=%b exp=1", held); end
    do_start(7'd5);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL pause_resume got=%0d exp=1", state); end
    wait_tick(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL pause_next_tick got=%0d exp=2", n); end
    checks++; if (timer !== 7'd98 || LED !== 1'b1) begin errors++; $display("FAIL pause_after got=%0d/%b exp=98/1", timer, LED); end
  endtask

  task automatic test_clear_start();
    cyc(1);
    clear = 1'b1;
    start = 1'b1;
    load_val = 7'd60;
    cyc(1);
    clear = 1'b0;
    start = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL clr_state got=%0d exp=0", state); end
    checks++; if (timer !== 7'd0) begin errors++; $display("FAIL clr_timer got=%0d exp=0", timer); end
    checks++; if (LED !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL clr_led_done got=%b/%b exp=0/0", LED, done); end
  endtask

  task automatic test_async_reset();
    int n;
    do_start(7'd3);
    wait_tick(n);
    checks++; if (state !== 3'd2 || timer !== 7'd2) begin errors++; $display("FAIL ares_pre got=%0d/%0d exp=2/2", state, timer); end
    cyc(1);
    #2;
    Resetn = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || timer !== 7'd0) begin errors++; $display("FAIL ares_st_tm got=%0d/%0d exp=0/0", state, timer); end
    checks++; if (LED !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL ares_out got=%b%b%b exp=000", LED, done, tick); end
    @(negedge Clock_50);
    Resetn = 1'b1;
    cyc(1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn   = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;
    load_val = 7'd0;
    test_reset();
    test_slow_pattern();
    test_fast_threshold();
`ifdef BLINK_SEQ_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_done();
`endif
    test_pause();
    test_clear_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
